// File: rtl/pll_relock_pkg.sv
// Shared types and constants for the PLL relock sequencer.
package pll_relock_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    BYP  = 3'd1,
    OFF  = 3'd2,
    PROG = 3'd3,
    LOCK = 3'd4,
    REL  = 3'd5,
    ERR  = 3'd6
  } state_t;

  localparam logic [9:0] RATIO_RST_DEF = 10'hBC;
  localparam logic [9:0] ZDIV0_RST_DEF = 10'hC7;

endpackage

// File: rtl/pll_seq_timer.sv
// Saturating up-counter with clear, load and a terminal-count compare.
module pll_seq_timer #(
  parameter int CNT_W = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             inc,
  input  logic [CNT_W-1:0] term,
  output logic             at_term
);

  logic [CNT_W-1:0] count;

  // Clear beats load beats increment; the count sticks at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign at_term = (count == term);

endmodule

// File: rtl/pll_relock_seq.sv
// Sequences a glitch-safe PLL ratio change: bypass, power-cycle, program, wait for lock, release.
module pll_relock_seq
  import pll_relock_pkg::*;
#(
  parameter int RATIO_W      = 10,
  parameter int ZDIV_W       = 10,
  parameter int OFF_CYC      = 16,
  parameter int SETTLE_CYC   = 64,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int CNT_W        = 13,
  parameter logic [RATIO_W-1:0] RATIO_RST = RATIO_RST_DEF,
  parameter logic [ZDIV_W-1:0]  ZDIV0_RST = ZDIV0_RST_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [RATIO_W-1:0] req_ratio,
  input  logic [ZDIV_W-1:0]  req_zdiv0,
  input  logic               pll_lock,
  input  logic               err_clr,
  output logic               pll_en,
  output logic               pll_bypass,
  output logic [RATIO_W-1:0] pll_ratio,
  output logic [ZDIV_W-1:0]  pll_zdiv0,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam logic [CNT_W-1:0] OFF_TERM    = CNT_W'(OFF_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_TERM = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_TERM = CNT_W'(SETTLE_CYC - 1);

  state_t             state, state_n;
  logic               phase_tc, settle_tc;
  logic [RATIO_W-1:0] ratio_q;
  logic [ZDIV_W-1:0]  zdiv0_q;

  // Terminal compares fire one cycle early so the count equals the cycles spent in the state.
  pll_seq_timer #(.CNT_W(CNT_W)) u_phase_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (state_n != state),
    .load     (1'b0),
    .load_val ('0),
    .inc      (1'b1),
    .term     ((state == OFF) ? OFF_TERM : TIMEOUT_TERM),
    .at_term  (phase_tc)
  );

  pll_seq_timer #(.CNT_W(CNT_W)) u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    ((state_n != state) || !pll_lock),
    .load     (1'b0),
    .load_val ('0),
    .inc      (1'b1),
    .term     (SETTLE_TERM),
    .at_term  (settle_tc)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (req_valid && req_ready) state_n = BYP;
      BYP:  state_n = OFF;
      OFF:  if (phase_tc) state_n = PROG;
      PROG: state_n = LOCK;
      LOCK: begin
        if (pll_lock && settle_tc) state_n = REL;
        else if (phase_tc)         state_n = ERR;
      end
      REL:  state_n = IDLE;
      ERR:  if (err_clr) state_n = BYP;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      pll_en     <= 1'b1;
      pll_bypass <= 1'b0;
      pll_ratio  <= RATIO_RST;
      pll_zdiv0  <= ZDIV0_RST;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      ratio_q    <= RATIO_RST;
      zdiv0_q    <= ZDIV0_RST;
    end else begin
      state      <= state_n;
      req_ready  <= (state_n == IDLE);
      pll_en     <= !(state_n inside {OFF, PROG, ERR});
      pll_bypass <= (state_n inside {BYP, OFF, PROG, LOCK, ERR});
      busy       <= (state_n != IDLE);
      done       <= (state_n == REL);
      err        <= (state_n == ERR);
      if (req_valid && req_ready) begin
        ratio_q <= req_ratio;
        zdiv0_q <= req_zdiv0;
      end
      if (state == PROG) begin
        pll_ratio <= ratio_q;
        pll_zdiv0 <= zdiv0_q;
      end
    end
  end

endmodule

// File: tb/tb_pll_relock_seq.sv
// Randomized and directed checks of the PLL relock sequencer against a lock-run model.
module tb_pll_relock_seq;

  localparam int OFF_CYC      = 16;
  localparam int SETTLE_CYC   = 64;
  localparam int LOCK_TIMEOUT = 4096;
  localparam int LOCK_START   = OFF_CYC + 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [9:0] req_ratio = '0;
  logic [9:0] req_zdiv0 = '0;
  logic       pll_lock = 1'b0;
  logic       err_clr = 1'b0;
  logic       pll_en, pll_bypass, busy, done, err;
  logic [9:0] pll_ratio, pll_zdiv0;

  int tests = 0;
  int fails = 0;
  int done_at;
  bit lock_pat [0:8191];
  logic [9:0] cur_r, cur_z, nr, nz;
  int d_c, e_c;

  pll_relock_seq dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_ratio  (req_ratio),
    .req_zdiv0  (req_zdiv0),
    .pll_lock   (pll_lock),
    .err_clr    (err_clr),
    .pll_en     (pll_en),
    .pll_bypass (pll_bypass),
    .pll_ratio  (pll_ratio),
    .pll_zdiv0  (pll_zdiv0),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fillLock(input bit val);
    for (int i = 0; i < 8192; i++) lock_pat[i] = val;
  endtask

  // Done follows the first run of SETTLE_CYC consecutive lock cycles inside the LOCK window.
  task automatic modelEnd(output int done_c, output int err_c);
    int run;
    run = 0;
    done_c = -1;
    err_c = -1;
    for (int r = LOCK_START; r < LOCK_START + LOCK_TIMEOUT; r++) begin
      run = lock_pat[r] ? run + 1 : 0;
      if (run == SETTLE_CYC) begin
        done_c = r + 1;
        return;
      end
    end
    err_c = LOCK_START + LOCK_TIMEOUT;
  endtask

  task automatic checkIdle(input string tag, input logic [9:0] r, input logic [9:0] z);
    checkOutput({tag, "_en"}, pll_en, 1);
    checkOutput({tag, "_byp"}, pll_bypass, 0);
    checkOutput({tag, "_ratio"}, pll_ratio, r);
    checkOutput({tag, "_zdiv"}, pll_zdiv0, z);
    checkOutput({tag, "_ready"}, req_ready, 1);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_err"}, err, 0);
  endtask

  // Caller leaves the triggering input (req_valid or err_clr) high for cycle 0.
  task automatic applyStimulus(input logic [9:0] old_r, input logic [9:0] old_z,
                               input logic [9:0] new_r, input logic [9:0] new_z,
                               input bit poke, output int done_c, output int err_c);
    int last;
    bit in_err, is_done, is_idle;
    modelEnd(done_c, err_c);
    last = (done_c > 0) ? done_c + 1 : err_c + 2;
    done_at = -1;
    for (int r = 1; r <= last; r++) begin
      step();
      if (done === 1'b1 && done_at < 0) done_at = r;
      in_err  = (err_c > 0) && (r >= err_c);
      is_done = (r == done_c);
      is_idle = (done_c > 0) && (r == done_c + 1);
      checkOutput("seq_en", pll_en, !(((r >= 2) && (r < LOCK_START)) || in_err));
      checkOutput("seq_byp", pll_bypass, !(is_done || is_idle));
      checkOutput("seq_busy", busy, !is_idle);
      checkOutput("seq_done", done, is_done);
      checkOutput("seq_err", err, in_err);
      checkOutput("seq_ready", req_ready, is_idle);
      checkOutput("seq_ratio", pll_ratio, (r < LOCK_START) ? old_r : new_r);
      checkOutput("seq_zdiv", pll_zdiv0, (r < LOCK_START) ? old_z : new_z);
      pll_lock  = lock_pat[r];
      err_clr   = 1'b0;
      req_valid = poke && (r >= 3) && (r <= 8);
      if (poke) begin
        req_ratio = ~new_r;
        req_zdiv0 = ~new_z;
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic startReq(input logic [9:0] r, input logic [9:0] z);
    req_ratio = r;
    req_zdiv0 = z;
    req_valid = 1'b1;
  endtask

  initial begin
    // Reset held for two cycles.
    step();
    step();
    checkIdle("reset", 10'hBC, 10'hC7);
    rst = 1'b0;
    step();
    checkIdle("post_reset", 10'hBC, 10'hC7);
    cur_r = 10'hBC;
    cur_z = 10'hC7;

    // Nominal change with lock tied high.
    fillLock(1'b1);
    pll_lock = 1'b1;
    startReq(10'h064, 10'h031);
    applyStimulus(cur_r, cur_z, 10'h064, 10'h031, 1'b0, d_c, e_c);
    checkOutput("nominal_done_cycle", done_at, 83);
    cur_r = 10'h064;
    cur_z = 10'h031;

    // Single-cycle lock drop 30 cycles into LOCK.
    fillLock(1'b1);
    lock_pat[LOCK_START + 30] = 1'b0;
    startReq(10'h1A5, 10'h2F0);
    applyStimulus(cur_r, cur_z, 10'h1A5, 10'h2F0, 1'b0, d_c, e_c);
    checkOutput("glitch_done_cycle", done_at, 114);
    cur_r = 10'h1A5;
    cur_z = 10'h2F0;

    // Busy request during OFF must be ignored.
    fillLock(1'b1);
    startReq(10'h2AA, 10'h155);
    applyStimulus(cur_r, cur_z, 10'h2AA, 10'h155, 1'b1, d_c, e_c);
    cur_r = 10'h2AA;
    cur_z = 10'h155;
    checkIdle("after_busy", cur_r, cur_z);

    // Randomized ratios and lock patterns.
    for (int t = 0; t < 6; t++) begin
      nr = 10'($urandom_range(0, 1023));
      nz = 10'($urandom_range(0, 1023));
      fillLock(1'b1);
      for (int i = 0; i < 200; i++) lock_pat[i] = ($urandom_range(0, 99) >= 3);
      startReq(nr, nz);
      applyStimulus(cur_r, cur_z, nr, nz, ($urandom_range(0, 1) == 1), d_c, e_c);
      cur_r = nr;
      cur_z = nz;
    end

    // err_clr outside ERR has no effect.
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    step();
    checkIdle("errclr_idle", cur_r, cur_z);

    // Lock never arrives: timeout, then retry via err_clr.
    fillLock(1'b0);
    pll_lock = 1'b0;
    startReq(10'h0F0, 10'h00F);
    applyStimulus(cur_r, cur_z, 10'h0F0, 10'h00F, 1'b0, d_c, e_c);
    checkOutput("timeout_err", err, 1);
    cur_r = 10'h0F0;
    cur_z = 10'h00F;
    fillLock(1'b1);
    pll_lock = 1'b1;
    err_clr = 1'b1;
    applyStimulus(cur_r, cur_z, cur_r, cur_z, 1'b0, d_c, e_c);
    checkOutput("retry_done_cycle", done_at, 83);

    // Reset while in LOCK.
    startReq(10'h3FF, 10'h3FE);
    step();
    req_valid = 1'b0;
    repeat (39) step();
    checkOutput("midrst_in_lock", pll_bypass, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkIdle("midrst", 10'hBC, 10'hC7);
    step();
    checkIdle("midrst_after", 10'hBC, 10'hC7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pll_relock_seq.md
Name: pll_relock_seq

Overview:
- Sequences a glitch-safe PLL frequency change on behalf of software or the SPI/pllmap front end.
- Accepts a new feedback ratio and zdiv0 ratio through a valid/ready request.
- Switches the PLL into bypass, power-cycles it, programs the new ratios, waits for a stable lock, then releases bypass.
- Sits between the register/map layer and the PLL control bundle. It owns the pllen, bypass, ratio and zdiv0_ratio fields.

Parameters:
RATIO_W, 10, width of feedback ratio
ZDIV_W, 10, width of zdiv0 ratio
OFF_CYC, 16, cycles pllen is held low (min 1)
SETTLE_CYC, 64, consecutive cycles of lock required (min 1)
LOCK_TIMEOUT, 4096, max cycles in LOCK before error (must be > SETTLE_CYC)
CNT_W, 13, timer width, must hold LOCK_TIMEOUT
RATIO_RST, 10'hBC, reset ratio
ZDIV0_RST, 10'hC7, reset zdiv0 ratio

Ports:
clk  in  1  single clock
rst  in  1  synchronous, active-high reset
req_valid  in  1  new ratio request
req_ready  out  1  high only in IDLE
req_ratio  in  RATIO_W  requested feedback ratio
req_zdiv0  in  ZDIV_W  requested zdiv0 ratio
pll_lock  in  1  PLL lock indicator, already synchronised to clk
err_clr  in  1  clears error state
pll_en  out  1  PLL enable
pll_bypass  out  1  PLL bypass select
pll_ratio  out  RATIO_W  programmed ratio
pll_zdiv0  out  ZDIV_W  programmed zdiv0 ratio
busy  out  1  sequence in progress (not IDLE)
done  out  1  one-cycle pulse on successful completion
err  out  1  sticky lock-timeout flag

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. All outputs are registered.
- Reset values: state IDLE, pll_en=1, pll_bypass=0, pll_ratio=RATIO_RST, pll_zdiv0=ZDIV0_RST, busy=0, done=0, err=0, timers=0.
- Accept: a handshake occurs when req_valid&&req_ready at a rising edge. req_ratio and req_zdiv0 are latched on that edge.
- While not IDLE, req_ready=0, and req_valid is ignored without being queued.
- Cycle 0 is the accept cycle. States and their outputs:
  - IDLE: pll_en=1, bypass=0. Goes to BYP on accept.
  - BYP (1 cycle): bypass=1, pll_en=1. Goes to OFF.
  - OFF (OFF_CYC cycles): pll_en=0, bypass=1. Goes to PROG when the timer expires.
  - PROG (1 cycle): pll_ratio and pll_zdiv0 load the latched values; pll_en=0. Goes to LOCK.
  - LOCK: pll_en=1, bypass=1. Two counters run:
    - Settle counter increments while pll_lock=1 and clears to 0 whenever pll_lock=0.
    - Timeout counter increments every cycle.
    - When the settle counter reaches SETTLE_CYC, go to REL.
    - Otherwise, when the timeout counter reaches LOCK_TIMEOUT, go to ERR.
    - If both occur in the same cycle, settle wins.
  - REL (1 cycle): bypass=0, pll_en=1, done=1. Goes to IDLE.
  - ERR: err=1, pll_en=0, bypass=1, pll_ratio holds the new value. Stays until err_clr=1, then clears err and goes to BYP. This retries the same latched request without a new handshake.
- err_clr outside ERR has no effect.
- With lock held high, done is high in cycle OFF_CYC+SETTLE_CYC+3, which is cycle 83 at default parameters.
- pll_bypass is 1 in every state from BYP through LOCK. The PLL output is therefore never selected while pllen or the ratio changes.
- Ratios change only in PROG, never while pll_en=1.
- rst asserted mid-sequence: on the next edge all outputs return to reset values, including ratios back to RATIO_RST/ZDIV0_RST. Any in-flight request is dropped.
- Timer arithmetic: counters saturate and never wrap. OFF and the LOCK counters are cleared on state entry.

Decomposition:
- Package pll_relock_pkg holds:
  - state enum: IDLE, BYP, OFF, PROG, LOCK, REL, ERR, 3-bit encoding;
  - default ratio constants.
- The PLL control bundle typedef stays in pllMap_pkg.
- One sub-module, pll_seq_timer: a loadable, saturating up-counter with clear and a terminal-count compare. It is instantiated for the OFF/timeout timer and for the settle counter.

Test Plan:
- Reset then idle: rst held 2 cycles -> pll_en=1, pll_bypass=0, pll_ratio=0xBC, pll_zdiv0=0xC7, req_ready=1, err=0.
- Nominal change: req ratio=0x64, zdiv0=0x31, pll_lock tied 1 -> bypass=1 from cycle 1, pll_en=0 in cycles 2–18, ratio=0x64 from cycle 19, done pulse in cycle 83 only, bypass=0 at cycle 83, req_ready=1 at cycle 84.
- Lock glitch: pll_lock drops for 1 cycle 30 cycles into LOCK -> settle restarts, and done is delayed by 31 cycles relative to nominal.
- Timeout: pll_lock=0 throughout -> err=1 after 4096 LOCK cycles, pll_en=0, bypass=1. Then err_clr with lock=1 -> err=0, sequence reruns from BYP, and done follows.
- Busy request: second req_valid during OFF -> req_ready=0, and the second request is not applied. The final ratio equals the first request.
- Mid-sequence reset: rst in LOCK -> next cycle ratio=0xBC, pll_en=1, bypass=0, busy=0, no done pulse.
